pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Measures one complementary gate pair (SHi/SLo) driven by a PWM phase leg.
- Reports, in MClk cycles: period, high time, and the dead time before each edge.
- Flags shoot-through, where both switches are on.
- Used on the loopback/monitor side of the PWM generator to close the loop on duty cycle and dead-time settings.

Parameters:
BIT_WIDTH, 16, width of all count/measurement outputs
FilterLen, 3, consecutive stable cycles required by the glitch filter (only used with PWM_CAP_FILTER_EN; legal range 2..15)

Ports:
MClk  input  1  system clock, all logic on rising edge
RstN  input  1  asynchronous active-low reset
Enable  input  1  1 = capture runs; 0 = return to WAIT_FIRST and clear counters
ClearFault  input  1  synchronous clear of ShootThrough and Timeout
SHi  input  1  high-side gate signal, asynchronous to MClk
SLo  input  1  low-side gate signal, asynchronous to MClk
Period  output  BIT_WIDTH  cycles between consecutive SHi rising edges
HighTime  output  BIT_WIDTH  cycles SHi was high within that period
DeadRise  output  BIT_WIDTH  both-low cycles immediately preceding the SHi rise
DeadFall  output  BIT_WIDTH  both-low cycles immediately preceding the SLo rise
Valid  output  1  one-cycle pulse when Period/HighTime/DeadRise update
ShootThrough  output  1  sticky: both synced inputs high at some cycle
Timeout  output  1  sticky: no SHi rise within 2^BIT_WIDTH-1 cycles

Behaviour:
- Reset: all outputs 0, all counters 0, state WAIT_FIRST.
- Reset is asynchronous. Assertion mid-measurement discards partial counts; no Valid is issued.
- Input conditioning:
  - Each input passes through a 2-flop synchroniser, then the optional filter, giving hs/ls.
  - Edges are detected against the previous value: rise = hs & ~hs_d.
  - Valid asserts 3 cycles after the SHi pin edge that closes a period (FilterLen more with the filter).
- States:
  - WAIT_FIRST: counters held at 0. On hs rise with Enable=1: PerCnt<=1, HiCnt<=1, go to RUN. No Valid is issued.
  - RUN, each cycle:
    - PerCnt++.
    - HiCnt++ if hs=1.
    - DtCnt++ if hs=0 & ls=0; otherwise DtCnt<=0.
  - RUN, on hs rise:
    - Period<=PerCnt, HighTime<=HiCnt, DeadRise<=DtCnt.
    - Valid<=1 for one cycle.
    - PerCnt<=1, HiCnt<=1, DtCnt<=0.
  - RUN, on ls rise: DeadFall<=DtCnt, DtCnt<=0. Valid is not affected.
  - RUN, timeout: if PerCnt reaches all-ones without an hs rise, set Timeout and go to WAIT_FIRST. No Valid is issued; measurement outputs hold.
  - Enable=0 from any state: go to WAIT_FIRST, clear counters; measurement outputs hold their last values.
- Simultaneous hs rise and ls rise in one cycle:
  - ShootThrough is set.
  - Both captures occur and both take the same DtCnt.
- ShootThrough is set on any cycle with hs=1 & ls=1, in either state.
- ClearFault clears ShootThrough and Timeout. If the setting condition is present in the same cycle, set wins.
- Counter widths: all counters are BIT_WIDTH and saturate, never wrap. HiCnt ≤ PerCnt always.
- 100% duty (hs never falls) yields Timeout. 0% duty also yields Timeout.

Optional Feature:
- Macro: PWM_CAP_FILTER_EN.
- Defined:
  - A per-input glitch filter sits after the synchroniser.
  - The filtered output changes only after the synced input differs from it for FilterLen consecutive cycles.
  - Shorter pulses are ignored.
  - Adds FilterLen cycles of latency; measured widths are unaffected for clean inputs.
- Undefined: filter logic is absent and hs/ls equal the synchroniser outputs.

Test Plan:
- Complementary square wave, period 100, SHi high 40, 5-cycle both-low gap before each edge -> after the 2nd SHi rise, Valid pulses every 100 cycles with Period=100, HighTime=40, DeadRise=5, DeadFall=5; ShootThrough=0.
- Reset asserted at cycle 50 of a period -> all outputs 0 immediately. After release, the first Valid comes only after two SHi rises.
- SHi held high for 70000 cycles (BIT_WIDTH=16) -> Timeout=1 at PerCnt=65535, no Valid. A ClearFault pulse then clears it.
- SHi and SLo overlap high for 2 cycles -> ShootThrough=1 and stays 1 until ClearFault. ClearFault during an ongoing overlap leaves it 1.
- Enable dropped mid-period, then raised -> no Valid until two new SHi rises. Period/HighTime hold their prior values throughout.
- With PWM_CAP_FILTER_EN, FilterLen=3: a 2-cycle SLo glitch inside the dead time -> DeadRise unaffected (full gap counted). Without the macro, the same stimulus -> DeadRise equals the cycles after the glitch only.

Source files
------------

// File: rtl/pwm_capture.sv
// Complementary gate-pair monitor: measures period, high time and dead times in MClk cycles.
// Optional glitch filter on the synchronised inputs is enabled with `define PWM_CAP_FILTER_EN.
module pwm_capture #(
    parameter int BIT_WIDTH = 16,
    parameter int FilterLen = 3
) (
    input  logic                 MClk,
    input  logic                 RstN,
    input  logic                 Enable,
    input  logic                 ClearFault,
    input  logic                 SHi,
    input  logic                 SLo,
    output logic [BIT_WIDTH-1:0] Period,
    output logic [BIT_WIDTH-1:0] HighTime,
    output logic [BIT_WIDTH-1:0] DeadRise,
    output logic [BIT_WIDTH-1:0] DeadFall,
    output logic                 Valid,
    output logic                 ShootThrough,
    output logic                 Timeout
);

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        RUN        = 1'b1
    } state_t;

    localparam logic [BIT_WIDTH-1:0] CNT_ONE = BIT_WIDTH'(1);

    function automatic logic [BIT_WIDTH-1:0] sat_inc(input logic [BIT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_shi_p0, r_shi_p1, r_slo_p0, r_slo_p1;
    logic                 w_hs, w_ls;
    logic                 r_hs_d, r_ls_d;
    logic                 w_hs_rise, w_ls_rise;
    logic                 w_capture, w_df_capture, w_timeout_evt, w_both_on;
    logic [BIT_WIDTH-1:0] r_per_cnt, r_hi_cnt, r_dt_cnt;
    logic [BIT_WIDTH-1:0] r_period, r_high, r_dead_rise, r_dead_fall;
    logic                 r_valid, r_shoot, r_timeout;

    // Two-flop synchronisers for the asynchronous gate signals
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_shi_p0 <= 1'b0;
            r_shi_p1 <= 1'b0;
            r_slo_p0 <= 1'b0;
            r_slo_p1 <= 1'b0;
        end else begin
            r_shi_p0 <= SHi;
            r_shi_p1 <= r_shi_p0;
            r_slo_p0 <= SLo;
            r_slo_p1 <= r_slo_p0;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam logic [3:0] FLT_MAX = 4'(FilterLen - 1);

    logic       r_hs_flt, r_ls_flt;
    logic [3:0] r_hs_fcnt, r_ls_fcnt;

    // Filtered level follows the synced input only after FilterLen consecutive differing cycles
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_hs_flt  <= 1'b0;
            r_ls_flt  <= 1'b0;
            r_hs_fcnt <= '0;
            r_ls_fcnt <= '0;
        end else begin
            if (r_shi_p1 != r_hs_flt) begin
                if (r_hs_fcnt == FLT_MAX) begin
                    r_hs_flt  <= r_shi_p1;
                    r_hs_fcnt <= '0;
                end else begin
                    r_hs_fcnt <= r_hs_fcnt + 4'd1;
                end
            end else begin
                r_hs_fcnt <= '0;
            end
            if (r_slo_p1 != r_ls_flt) begin
                if (r_ls_fcnt == FLT_MAX) begin
                    r_ls_flt  <= r_slo_p1;
                    r_ls_fcnt <= '0;
                end else begin
                    r_ls_fcnt <= r_ls_fcnt + 4'd1;
                end
            end else begin
                r_ls_fcnt <= '0;
            end
        end
    end

    assign w_hs = r_hs_flt;
    assign w_ls = r_ls_flt;
`else
    logic w_unused_flt;
    assign w_unused_flt = (FilterLen != 0);
    assign w_hs         = r_shi_p1;
    assign w_ls         = r_slo_p1;
`endif

    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_hs_d <= 1'b0;
            r_ls_d <= 1'b0;
        end else begin
            r_hs_d <= w_hs;
            r_ls_d <= w_ls;
        end
    end

    assign w_hs_rise    = w_hs & ~r_hs_d;
    assign w_ls_rise    = w_ls & ~r_ls_d;
    assign w_both_on    = w_hs & w_ls;
    assign w_df_capture = Enable && (r_state == RUN) && w_ls_rise;

    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) r_state <= WAIT_FIRST;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_timeout_evt = 1'b0;
        if (!Enable) begin
            w_state_nxt = WAIT_FIRST;
        end else begin
            case (r_state)
                WAIT_FIRST: if (w_hs_rise) w_state_nxt = RUN;
                RUN: begin
                    if (w_hs_rise) begin
                        w_capture = 1'b1;
                    end else if (r_per_cnt == '1) begin
                        w_timeout_evt = 1'b1;
                        w_state_nxt   = WAIT_FIRST;
                    end
                end
                default: w_state_nxt = WAIT_FIRST;
            endcase
        end
    end

    // Measurement counters; an hs rise restarts a period with its first cycle already counted
    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_dt_cnt  <= '0;
        end else if (!Enable || w_timeout_evt) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_dt_cnt  <= '0;
        end else if (r_state == WAIT_FIRST) begin
            r_per_cnt <= w_hs_rise ? CNT_ONE : '0;
            r_hi_cnt  <= w_hs_rise ? CNT_ONE : '0;
            r_dt_cnt  <= '0;
        end else begin
            r_per_cnt <= w_hs_rise ? CNT_ONE : sat_inc(r_per_cnt);
            if (w_hs_rise)  r_hi_cnt <= CNT_ONE;
            else if (w_hs)  r_hi_cnt <= sat_inc(r_hi_cnt);
            r_dt_cnt  <= (!w_hs && !w_ls) ? sat_inc(r_dt_cnt) : '0;
        end
    end

    always_ff @(posedge MClk or negedge RstN) begin
        if (!RstN) begin
            r_period    <= '0;
            r_high      <= '0;
            r_dead_rise <= '0;
            r_dead_fall <= '0;
            r_valid     <= 1'b0;
            r_shoot     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_period    <= r_per_cnt;
                r_high      <= r_hi_cnt;
                r_dead_rise <= r_dt_cnt;
            end
            if (w_df_capture) r_dead_fall <= r_dt_cnt;
            if (w_both_on)       r_shoot <= 1'b1;
            else if (ClearFault) r_shoot <= 1'b0;
            if (w_timeout_evt)   r_timeout <= 1'b1;
            else if (ClearFault) r_timeout <= 1'b0;
        end
    end

    assign Period       = r_period;
    assign HighTime     = r_high;
    assign DeadRise     = r_dead_rise;
    assign DeadFall     = r_dead_fall;
    assign Valid        = r_valid;
    assign ShootThrough = r_shoot;
    assign Timeout      = r_timeout;

endmodule
